// File: rtl/xspi_octal_slave_param.sv
// Octal xSPI slave: command, address, CA CRC-8, then a write or read data phase with its own CRC-8,
// an internal MEM_DEPTH-word memory, and bounded retransmission. Define XSPI_STATUS_CMD_EN to add the 8'h05 status read.
module xspi_octal_slave_param #(
  parameter int          ADDR_BYTES = 6,
  parameter int          DATA_BYTES = 8,
  parameter int          MEM_DEPTH  = 16,
  parameter int          LATENCY    = 6,
  parameter int          MAX_RETRY  = 3,
  parameter logic [7:0]  CMD_READ   = 8'hFF,
  parameter logic [7:0]  CMD_WRITE  = 8'hA5,
  parameter logic [7:0]  CRC_POLY   = 8'h07
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_oe,
  output logic       data_strobe,
  output logic       ready,
  output logic       crc_ca_match,
  output logic       crc_ca_error,
  output logic       crc_data_match,
  output logic       crc_data_error,
  input  logic       crc_ca_error_master,
  input  logic       crc_data_error_master,
  output logic [3:0] retry_cnt,
  output logic       retry_exhausted,
  output logic       cmd_error
);
  localparam int DW = DATA_BYTES * 8;
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [7:0] CMD_STATUS = 8'h05;
`ifdef XSPI_STATUS_CMD_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_CRC_CA   = 4'd2;
  localparam logic [3:0] S_LAT      = 4'd3;
  localparam logic [3:0] S_RD_DATA  = 4'd4;
  localparam logic [3:0] S_RD_CRC   = 4'd5;
  localparam logic [3:0] S_WR_DATA  = 4'd6;
  localparam logic [3:0] S_WR_CRC   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_RETRY    = 4'd9;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    return r;
  endfunction

  logic [3:0]    state;
  logic [4:0]    cnt, rd_last;
  logic [7:0]    cmd, crc_ca, crc_d;
  logic [IW-1:0] idx, idx_nxt;
  logic [DW-1:0] stage, rd_sh;
  logic [DW-1:0] mem [MEM_DEPTH];
  logic [7:0]    rd_byte, status_byte;
  logic [3:0]    last_retry;
  logic          last_ca_err, last_d_err, last_exh, last_cmd_err;
  logic          abort, err, commit, ca_ok, is_read;

  // Only the low index bits of the address are kept; upper bytes shift out.
  always_comb begin
    idx_nxt     = IW'({idx, io_in});
    rd_byte     = rd_sh[DW-1 -: 8];
    status_byte = {last_retry, last_ca_err, last_d_err, last_exh, last_cmd_err};
    abort       = cs_n && (state != S_IDLE) && (state != S_DONE) && (state != S_RETRY);
    err         = crc_ca_error | crc_data_error | crc_ca_error_master | crc_data_error_master;
    ca_ok       = (io_in == crc_ca);
    is_read     = (cmd == CMD_READ) || (STATUS_EN && (cmd == CMD_STATUS));
    commit      = (state == S_WR_CRC) && !cs_n && crc_ca_match && (io_in == crc_d);
  end

  always_ff @(posedge clk) begin
    if (!rst && commit) mem[idx] <= stage;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;  cnt <= '0;  rd_last <= '0;  cmd <= '0;
      crc_ca <= '0;  crc_d <= '0;  idx <= '0;  stage <= '0;  rd_sh <= '0;
      io_out <= '0;  io_oe <= 1'b0;  data_strobe <= 1'b0;  ready <= 1'b0;
      crc_ca_match <= 1'b0;  crc_ca_error <= 1'b0;
      crc_data_match <= 1'b0;  crc_data_error <= 1'b0;
      retry_cnt <= '0;  retry_exhausted <= 1'b0;  cmd_error <= 1'b0;
      last_retry <= '0;  last_ca_err <= 1'b0;  last_d_err <= 1'b0;
      last_exh <= 1'b0;  last_cmd_err <= 1'b0;
    end else begin
      ready           <= 1'b0;
      retry_exhausted <= 1'b0;
      if (abort) begin
        state <= S_IDLE;  io_oe <= 1'b0;  data_strobe <= 1'b0;  io_out <= '0;
        retry_cnt <= '0;  crc_d <= '0;  cnt <= '0;
      end else begin
        case (state)
          S_IDLE, S_RETRY: if (!cs_n) begin
            cmd <= io_in;  crc_ca <= crc8(8'h00, io_in);  crc_d <= '0;  cnt <= '0;
            crc_ca_match <= 1'b0;  crc_ca_error <= 1'b0;
            crc_data_match <= 1'b0;  crc_data_error <= 1'b0;  cmd_error <= 1'b0;
            state <= S_ADDR;
          end
          S_ADDR: begin
            idx    <= idx_nxt;
            crc_ca <= crc8(crc_ca, io_in);
            cnt    <= cnt + 5'd1;
            if (cnt == 5'(ADDR_BYTES - 1)) begin
              cnt   <= '0;
              state <= S_CRC_CA;
            end
          end
          S_CRC_CA: begin
            crc_ca_match <= ca_ok;
            crc_ca_error <= !ca_ok;
            rd_sh        <= mem[idx];
            rd_last      <= 5'(DATA_BYTES - 1);
            if (STATUS_EN && (cmd == CMD_STATUS)) begin
              rd_sh   <= DW'(status_byte) << (DW - 8);
              rd_last <= '0;
            end
            // Writes run the data phase even on a CA mismatch to keep the bus aligned.
            if (cmd == CMD_WRITE)    state <= S_WR_DATA;
            else if (is_read)        state <= ca_ok ? S_LAT : S_DONE;
            else begin
              cmd_error <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_LAT: begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'(LATENCY - 1)) begin
              cnt   <= '0;
              state <= S_RD_DATA;
            end
          end
          S_RD_DATA: begin
            io_oe       <= 1'b1;
            data_strobe <= 1'b1;
            io_out      <= rd_byte;
            crc_d       <= crc8(crc_d, rd_byte);
            rd_sh       <= rd_sh << 8;
            cnt         <= cnt + 5'd1;
            if (cnt == rd_last) begin
              cnt   <= '0;
              state <= S_RD_CRC;
            end
          end
          S_RD_CRC: begin
            io_out      <= crc_d;
            data_strobe <= 1'b1;
            state       <= S_DONE;
          end
          S_WR_DATA: begin
            stage <= DW'({stage, io_in});
            crc_d <= crc8(crc_d, io_in);
            cnt   <= cnt + 5'd1;
            if (cnt == 5'(DATA_BYTES - 1)) begin
              cnt   <= '0;
              state <= S_WR_CRC;
            end
          end
          S_WR_CRC: begin
            crc_data_match <= (io_in == crc_d);
            crc_data_error <= (io_in != crc_d);
            state          <= S_DONE;
          end
          S_DONE: begin
            io_oe <= 1'b0;  data_strobe <= 1'b0;  io_out <= '0;
            if (err && (retry_cnt < 4'(MAX_RETRY))) begin
              retry_cnt <= retry_cnt + 4'd1;
              crc_ca <= '0;  crc_d <= '0;
              crc_ca_match <= 1'b0;  crc_ca_error <= 1'b0;
              crc_data_match <= 1'b0;  crc_data_error <= 1'b0;
              state <= S_RETRY;
            end else begin
              ready           <= 1'b1;
              retry_exhausted <= err;
              last_retry      <= retry_cnt;
              last_ca_err     <= crc_ca_error;
              last_d_err      <= crc_data_error;
              last_exh        <= err;
              last_cmd_err    <= cmd_error;
              retry_cnt       <= '0;
              state           <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_xspi_octal_slave_param.sv
// Self-checking bench for xspi_octal_slave_param: randomized write/read frames against a memory/CRC model.
module tb_xspi_octal_slave_param;
  localparam int AB = 6, DB = 8, MD = 16, LATC = 6, MR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, cs_n = 1'b1;
  logic [7:0] io_in = '0, io_out;
  logic io_oe, data_strobe, ready, crc_ca_match, crc_ca_error, crc_data_match, crc_data_error;
  logic crc_ca_error_master = 1'b0, crc_data_error_master = 1'b0;
  logic [3:0] retry_cnt;
  logic retry_exhausted, cmd_error;

  always #5 clk = ~clk;

  xspi_octal_slave_param #(
    .ADDR_BYTES(AB), .DATA_BYTES(DB), .MEM_DEPTH(MD), .LATENCY(LATC), .MAX_RETRY(MR),
    .CMD_READ(8'hFF), .CMD_WRITE(8'hA5), .CRC_POLY(8'h07)
  ) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .data_strobe(data_strobe), .ready(ready),
    .crc_ca_match(crc_ca_match), .crc_ca_error(crc_ca_error),
    .crc_data_match(crc_data_match), .crc_data_error(crc_data_error),
    .crc_ca_error_master(crc_ca_error_master), .crc_data_error_master(crc_data_error_master),
    .retry_cnt(retry_cnt), .retry_exhausted(retry_exhausted), .cmd_error(cmd_error)
  );

  int total = 0, bad = 0;
  logic [63:0] mmem [MD];
  int m_retry = 0;

  // Bit-serial long division of the message by x^8+x^2+x+1.
  function automatic logic [7:0] crc_q(input logic [7:0] q[$]);
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    foreach (q[i])
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ q[i][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    return r;
  endfunction

  task automatic tick(input logic cs, input logic [7:0] d, input logic mca = 1'b0, input logic md = 1'b0);
    cs_n = cs;  io_in = d;  crc_ca_error_master = mca;  crc_data_error_master = md;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ca(input logic [7:0] c, input logic [47:0] a, input logic [7:0] flip);
    logic [7:0] q[$];
    q.push_back(c);
    for (int i = AB - 1; i >= 0; i--) q.push_back(a[i*8 +: 8]);
    foreach (q[i]) tick(1'b0, q[i]);
    tick(1'b0, crc_q(q) ^ flip);
  endtask

  task automatic finish_done(input logic err_local, input logic me, input string nm);
    logic e, exp_rdy, exp_exh;
    e = err_local | me;
    if (e && m_retry < MR) begin
      m_retry++;  exp_rdy = 1'b0;  exp_exh = 1'b0;
    end else begin
      exp_rdy = 1'b1;  exp_exh = e;  m_retry = 0;
    end
    tick(1'b1, 8'h00, 1'b0, me);
    total++;
    if ({ready, retry_exhausted, retry_cnt, io_oe} !== {exp_rdy, exp_exh, 4'(m_retry), 1'b0}) begin
      bad++;
      $display("FAIL %s done: got rdy=%b exh=%b retry=%0d oe=%b exp rdy=%b exh=%b retry=%0d oe=0",
               nm, ready, retry_exhausted, retry_cnt, io_oe, exp_rdy, exp_exh, m_retry);
    end
    tick(1'b1, 8'h00);
  endtask

  task automatic do_write(input logic [47:0] a, input logic [63:0] d, input logic [7:0] fca,
                          input logic [7:0] fd, input string nm);
    logic [7:0] q[$];
    send_ca(8'hA5, a, fca);
    total++;
    if ({crc_ca_match, crc_ca_error} !== {fca == 0, fca != 0}) begin
      bad++;
      $display("FAIL %s ca_crc: got %b%b exp %b%b", nm, crc_ca_match, crc_ca_error, fca == 0, fca != 0);
    end
    for (int i = DB - 1; i >= 0; i--) q.push_back(d[i*8 +: 8]);
    foreach (q[i]) tick(1'b0, q[i]);
    tick(1'b0, crc_q(q) ^ fd);
    total++;
    if ({crc_data_match, crc_data_error} !== {fd == 0, fd != 0}) begin
      bad++;
      $display("FAIL %s data_crc: got %b%b exp %b%b", nm, crc_data_match, crc_data_error, fd == 0, fd != 0);
    end
    if (fca == 0 && fd == 0) mmem[a % MD] = d;
    finish_done(fca != 0 || fd != 0, 1'b0, nm);
  endtask

  task automatic do_read(input logic [47:0] a, input logic me, input string nm);
    logic [63:0] w;
    logic [7:0] q[$];
    logic [7:0] exp_out;
    logic exp_oe, exp_st;
    int strobes;
    w = mmem[a % MD];
    for (int i = DB - 1; i >= 0; i--) q.push_back(w[i*8 +: 8]);
    send_ca(8'hFF, a, 8'h00);
    total++;
    if ({crc_ca_match, io_oe} !== 2'b10) begin
      bad++;
      $display("FAIL %s rd_ca: got match=%b oe=%b exp match=1 oe=0", nm, crc_ca_match, io_oe);
    end
    strobes = 0;
    for (int k = 1; k <= LATC + DB + 1; k++) begin
      tick(1'b0, 8'h00);
      exp_oe  = (k >= LATC + 1);
      exp_st  = exp_oe;
      exp_out = (k <= LATC) ? 8'h00 : (k <= LATC + DB) ? q[k - LATC - 1] : crc_q(q);
      strobes += int'(data_strobe);
      total++;
      if ({io_oe, data_strobe, io_out} !== {exp_oe, exp_st, exp_out}) begin
        bad++;
        $display("FAIL %s rd_cyc%0d: got oe=%b st=%b io=%h exp oe=%b st=%b io=%h",
                 nm, k, io_oe, data_strobe, io_out, exp_oe, exp_st, exp_out);
      end
    end
    total++;
    if (strobes != DB + 1) begin
      bad++;
      $display("FAIL %s strobe_len: got %0d exp %0d", nm, strobes, DB + 1);
    end
    finish_done(1'b0, me, nm);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 8'hA5);
    tick(1'b1, 8'h00);
    total++;
    if ({io_out, io_oe, data_strobe, ready, crc_ca_match, crc_ca_error, crc_data_match,
         crc_data_error, retry_cnt, retry_exhausted, cmd_error} !== 22'd0) begin
      bad++;
      $display("FAIL reset: got io=%h oe=%b st=%b rdy=%b retry=%0d exp all zero",
               io_out, io_oe, data_strobe, ready, retry_cnt);
    end
    rst = 1'b0;
    tick(1'b1, 8'h00);
  endtask

  task automatic test_write_read();
    do_write(48'h000000000003, 64'h1122334455667788, 8'h00, 8'h00, "wr_basic");
    do_read(48'h000000000003, 1'b0, "rd_basic");
  endtask

  task automatic test_random();
    logic [47:0] a;
    logic [63:0] d;
    for (int i = 0; i < 6; i++) begin
      a = {16'($urandom), 32'($urandom)};
      d = {32'($urandom), 32'($urandom)};
      do_write(a, d, 8'h00, 8'h00, "wr_rand");
      do_read({16'($urandom), 28'($urandom), a[3:0]}, 1'b0, "rd_rand");
    end
  endtask

  task automatic test_bad_data_crc();
    do_write(48'h5, 64'hCAFEF00D_DEADBEEF, 8'h00, 8'h00, "wr_old");
    do_write(48'h5, 64'h0123456789ABCDEF, 8'h00, 8'h01, "wr_bad_d");
    do_read(48'h5, 1'b0, "rd_unchanged");
    do_write(48'h5, 64'h0123456789ABCDEF, 8'h00, 8'h00, "wr_resend");
    do_read(48'h5, 1'b0, "rd_resend");
  endtask

  task automatic test_retry_exhaust();
    for (int i = 0; i < MR + 1; i++)
      do_write(48'h7, {32'($urandom), 32'($urandom)}, 8'h5A, 8'h00, "wr_bad_ca");
    do_read(48'h7, 1'b0, "rd_after_exh");
  endtask

  task automatic test_master_err();
    do_read(48'h9, 1'b1, "rd_master_err");
    do_read(48'h9, 1'b0, "rd_master_resend");
  endtask

  task automatic test_abort_opcode();
    do_write(48'h2, 64'h1, 8'h00, 8'h02, "wr_pre_abort");
    tick(1'b0, 8'hA5);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'($urandom));
    tick(1'b1, 8'h00);
    m_retry = 0;
    total++;
    if ({io_oe, ready, retry_cnt} !== 6'd0) begin
      bad++;
      $display("FAIL abort: got oe=%b rdy=%b retry=%0d exp 0 0 0", io_oe, ready, retry_cnt);
    end
    tick(1'b1, 8'h00);
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_noready: got %b exp 0", ready);
    end
    do_read(48'h2, 1'b0, "rd_post_abort");
    send_ca(8'h3C, 48'h2, 8'h00);
    total++;
    if (cmd_error !== 1'b1) begin
      bad++;
      $display("FAIL cmd_error: got %b exp 1", cmd_error);
    end
    finish_done(1'b0, 1'b0, "bad_opcode");
  endtask

  task automatic test_wrap();
    do_write(48'h13, 64'hA1B2C3D4E5F60718, 8'h00, 8'h00, "wr_wrap");
    do_read(48'h03, 1'b0, "rd_wrap");
  endtask

  initial begin
    for (int i = 0; i < MD; i++) mmem[i] = 64'hx;
    test_reset();
    test_write_read();
    test_random();
    test_bad_data_crc();
    test_retry_exhaust();
    test_master_err();
    test_abort_opcode();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xspi_octal_slave_param.md
Name: xspi_octal_slave_param

Overview:
- Parametrised octal xSPI slave, next generation of the single-word command/address/data slave.
- Frame per chip-select window: command byte, ADDR_BYTES address bytes, CRC-8 over command and address (CA), then a write or read data phase of DATA_BYTES with its own CRC-8.
- Backs a MEM_DEPTH-word internal memory and supports bounded CRC-driven retransmission with an explicit exhausted flag.
- Sits on the octal IO bus opposite the xSPI master; CRC is computed inline, so no external crc8 instance is needed.

Parameters:
- ADDR_BYTES, 6: address bytes per frame (1..8).
- DATA_BYTES, 8: data bytes per word (1..16).
- MEM_DEPTH, 16: memory words; power of 2, at least 2.
- LATENCY, 6: dummy cycles between the CA CRC byte and the first read byte (1..15).
- MAX_RETRY, 3: maximum retransmissions per frame (0..15).
- CMD_READ, 8'hFF: read opcode.
- CMD_WRITE, 8'hA5: write opcode.
- CRC_POLY, 8'h07: CRC-8 polynomial. MSB-first, init 8'h00, no reflection, no xorout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cs_n  in  1  chip select, active low.
- io_in  in  8  IO bus input.
- io_out  out  8  IO bus output.
- io_oe  out  1  IO output enable.
- data_strobe  out  1  high exactly in cycles where io_out carries read data or read CRC.
- ready  out  1  one-cycle pulse when a frame completes (success or retries exhausted).
- crc_ca_match / crc_ca_error  out  1 / 1  CA CRC compare result, held until the next frame or retry.
- crc_data_match / crc_data_error  out  1 / 1  write-data CRC compare result, held until the next frame or retry.
- crc_ca_error_master / crc_data_error_master  in  1 / 1  master-reported CRC errors, sampled in DONE.
- retry_cnt  out  4  retransmissions used in the current frame.
- retry_exhausted  out  1  one-cycle pulse alongside ready when a frame ends on an error with retry_cnt == MAX_RETRY.
- cmd_error  out  1  unknown opcode flag, held until the next frame.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; retry_cnt 0; CRC accumulators 0. Memory contents are not reset.
- One byte is sampled per clk while cs_n=0.
- cs_n=1 in any state other than IDLE or DONE aborts the frame:
  - next state IDLE, io_oe 0, no memory write, retry_cnt cleared, no ready pulse.
- IDLE: wait for cs_n=0. The same edge samples io_in as the command byte, loads CRC_CA = crc(0, byte), then moves to ADDR.
- ADDR: ADDR_BYTES cycles, MSB byte first, each folded into CRC_CA. The memory index is the low log2(MEM_DEPTH) address bits; upper bits are ignored.
- CRC_CA: one cycle; compare io_in with CRC_CA and set crc_ca_match / crc_ca_error. Next state:
  - opcode CMD_WRITE → WR_DATA. The write data phase proceeds even on a CA mismatch so the bus stays aligned, but the commit is suppressed.
  - opcode CMD_READ with CA match → LAT.
  - opcode CMD_READ with CA mismatch → DONE, io_oe stays 0.
  - other opcode → cmd_error=1, go to DONE.
- LAT: count LATENCY cycles. On the last one, set io_oe=1 and present data byte 0.
  - Byte 0 is therefore registered on edge LATENCY+1 after the CA CRC sample edge.
- RD_DATA: DATA_BYTES consecutive cycles, MSB byte first, folded into CRC_D; data_strobe=1.
- RD_CRC: drive CRC_D for one cycle with data_strobe=1, then go to DONE.
- WR_DATA: DATA_BYTES bytes into a staging register, each folded into CRC_D.
- WR_CRC: compare io_in with CRC_D and set crc_data_match / crc_data_error. Commit the staging register to mem[index] only if both the CA and data CRCs match. Go to DONE.
- DONE (one cycle): io_oe 0, data_strobe 0. Error is any of crc_ca_error, crc_data_error, crc_ca_error_master, crc_data_error_master.
  - Error and retry_cnt < MAX_RETRY: retry_cnt+1; clear CRCs and all match/error flags; go to RETRY_WAIT.
  - Otherwise: ready=1 for one cycle; retry_exhausted=1 if an error is present; retry_cnt ← 0; go to IDLE.
- RETRY_WAIT: hold until cs_n=0, then behave as IDLE (byte sampled as command), keeping retry_cnt.
- cs_n high during DONE or RETRY_WAIT is legal and not an abort.
- Simultaneous events: a master error input asserted in the same cycle as a local CRC match still counts as an error. The master inputs are ignored outside DONE.

Optional Feature:
- Macro: XSPI_STATUS_CMD_EN.
- Defined: opcode 8'h05 is a status read. It follows the read timing but has 1 data byte, no address index use, and is followed by its CRC. The status byte is {retry_cnt, last_crc_ca_error, last_crc_data_error, last_retry_exhausted, last_cmd_error} from the previous completed frame.
- Undefined: 8'h05 is an unknown opcode (cmd_error=1).

Test Plan:
- Write then read: write A5, address 0x000000000003, data 0x1122334455667788, correct CRCs. Expect crc_data_match=1 and a ready pulse. Then read FF to the same address: io_out bytes 11,22,…,88 starting at the CRC_CA edge +7, data_strobe high for 9 cycles, final byte = CRC-8 of those 8 bytes.
- Bad write data CRC: correct frame, data CRC byte XOR 0x01. Expect crc_data_error=1, memory unchanged (read returns the old value), retry_cnt=1, no ready; a correct resend then gives a ready pulse and retry_cnt back to 0.
- Retry exhaustion: 4 consecutive frames with a bad CA CRC and MAX_RETRY=3. Expect retry_cnt 1,2,3, then ready with retry_exhausted=1 and no memory write.
- Master-reported error: clean read with crc_data_error_master=1 in DONE. Expect retry_cnt=1 and RETRY_WAIT; the resend completes with ready.
- Abort and unknown opcode: cs_n high after address byte 3 → IDLE, no ready, io_oe=0. Opcode 0x3C with a valid CA CRC → cmd_error=1 and a ready pulse.
- Address wrap: MEM_DEPTH=16, write to address 0x13. A read of address 0x03 returns the same word.
